// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: pipeline and MDU producers, decode hazard queries,
// and the single register-file write port.
interface wb_port_arbiter_if;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    logic              pipe_valid;
    logic              pipe_regwrite;
    logic [REG_W-1:0]  pipe_rd;
    logic [DATA_W-1:0] pipe_data;
    logic              pipe_stall;

    logic              mdu_valid;
    logic [REG_W-1:0]  mdu_rd;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;

    logic [REG_W-1:0]  query_rs1;
    logic [REG_W-1:0]  query_rs2;
    logic              hit_rs1;
    logic              hit_rs2;

    logic              rf_we;
    logic [REG_W-1:0]  rf_rd;
    logic [DATA_W-1:0] rf_wdata;

    // Arbiter side
    modport slave (
        input  pipe_valid, pipe_regwrite, pipe_rd, pipe_data,
        input  mdu_valid, mdu_rd, mdu_data,
        input  query_rs1, query_rs2,
        output pipe_stall, mdu_ready, hit_rs1, hit_rs2,
        output rf_we, rf_rd, rf_wdata
    );

    // Producer / consumer side
    modport master (
        output pipe_valid, pipe_regwrite, pipe_rd, pipe_data,
        output mdu_valid, mdu_rd, mdu_data,
        output query_rs1, query_rs2,
        input  pipe_stall, mdu_ready, hit_rs1, hit_rs2,
        input  rf_we, rf_rd, rf_wdata
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the pipeline writeback and a
// 2-entry MDU result FIFO, with a starvation-bounded forced drain.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int unsigned REG_W    = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned STARVE_W = 4;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GRANT_IDLE,
        GRANT_PIPE,
        GRANT_FIFO
    } grant_e;

    // State
    wb_entry_t             fifo_q [DEPTH];
    logic [CNT_W-1:0]      count_q;
    logic [STARVE_W-1:0]   starve_q;
    logic                  rf_we_q;
    logic [REG_W-1:0]      rf_rd_q;
    logic [DATA_W-1:0]     rf_wdata_q;

    // Next state
    wb_entry_t             fifo_d [DEPTH];
    logic [CNT_W-1:0]      count_d;
    logic [STARVE_W-1:0]   starve_d;
    logic                  rf_we_d;
    logic [REG_W-1:0]      rf_rd_d;
    logic [DATA_W-1:0]     rf_wdata_d;

    // Combinational decisions
    grant_e                grant_c;
    logic                  mdu_ready_c;
    logic                  stall_c;
    logic                  live_c;
    logic                  pop_c;
    logic                  push_keep_c;
    logic                  hit1_c;
    logic                  hit2_c;

    assign mdu_ready_c = !rst && (count_q < CNT_W'(DEPTH));
    assign stall_c     = !rst && (count_q != '0) && (starve_q == STARVE_W'(STARVE_LIMIT));
    assign live_c      = bus.pipe_valid && bus.pipe_regwrite && (bus.pipe_rd != '0) && !stall_c;

    // Writes to x0 are acknowledged but never buffered.
    assign push_keep_c = bus.mdu_valid && mdu_ready_c && (bus.mdu_rd != '0);

    // Strict-priority port grant: forced drain, live pipeline, buffered head.
    always_comb begin
        grant_c = GRANT_IDLE;
        if (stall_c) begin
            grant_c = GRANT_FIFO;
        end else if (live_c) begin
            grant_c = GRANT_PIPE;
        end else if (count_q != '0) begin
            grant_c = GRANT_FIFO;
        end
    end

    assign pop_c = (grant_c == GRANT_FIFO);

    // Hazard lookup over occupied entries; the head still hits while popping.
    always_comb begin
        hit1_c = 1'b0;
        hit2_c = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                if ((bus.query_rs1 != '0) && (fifo_q[i].rd == bus.query_rs1)) begin
                    hit1_c = 1'b1;
                end
                if ((bus.query_rs2 != '0) && (fifo_q[i].rd == bus.query_rs2)) begin
                    hit2_c = 1'b1;
                end
            end
        end
    end

    // Next-state: write port, FIFO shift/append, starvation counter.
    always_comb begin
        fifo_d     = fifo_q;
        count_d    = count_q;
        starve_d   = starve_q;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;

        unique case (grant_c)
            GRANT_PIPE: begin
                rf_we_d    = 1'b1;
                rf_rd_d    = bus.pipe_rd;
                rf_wdata_d = bus.pipe_data;
            end
            GRANT_FIFO: begin
                rf_we_d    = 1'b1;
                rf_rd_d    = fifo_q[0].rd;
                rf_wdata_d = fifo_q[0].data;
            end
            default: ;
        endcase

        if (pop_c) begin
            fifo_d[0] = fifo_q[1];
            count_d   = count_q - CNT_W'(1);
        end

        // After any pop the occupancy is 0 or 1, so bit 0 is the free slot.
        if (push_keep_c) begin
            fifo_d[count_d[0]] = '{rd: bus.mdu_rd, data: bus.mdu_data};
            count_d            = count_d + CNT_W'(1);
        end

        if ((count_q == '0) || pop_c) begin
            starve_d = '0;
        end else begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            count_q    <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            fifo_q     <= fifo_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign bus.mdu_ready  = mdu_ready_c;
    assign bus.pipe_stall = stall_c;
    assign bus.hit_rs1    = !rst && hit1_c;
    assign bus.hit_rs2    = !rst && hit2_c;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_rd      = rf_rd_q;
    assign bus.rf_wdata   = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, hand-written corner
// sequences, and random traffic against a queue-based reference model.
module tb_wb_port_arbiter;
    localparam int unsigned LIM = 4;

    logic clk;
    logic rst;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        r, pv, pw;
        logic [4:0]  prd;
        logic [31:0] pdata;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic [4:0]  q1, q2;
        logic        x_ready, x_stall, x_h1, x_h2, x_we;
        logic [4:0]  x_rd;
        logic [31:0] x_wdata;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model state
    ent_t        m_q[$];
    int          m_starve = 0;
    logic        e_we = 1'b0;
    logic [4:0]  e_rd = '0;
    logic [31:0] e_wdata = '0;
    logic        prev_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic in_q(input logic [4:0] r);
        foreach (m_q[i]) if (m_q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_stall();
        return (m_q.size() > 0) && (m_starve == int'(LIM));
    endfunction

    // One cycle: drive at negedge, check combinational outputs, clock, check write port.
    task automatic apply(input logic r, input logic pv, input logic pw,
                         input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic [4:0] q1, input logic [4:0] q2,
                         output logic o_ready, output logic o_stall,
                         output logic o_h1, output logic o_h2);
        logic x_ready, x_stall, x_h1, x_h2, live, popped, was_empty;
        rst               = r;
        bus.pipe_valid    = pv;
        bus.pipe_regwrite = pw;
        bus.pipe_rd       = prd;
        bus.pipe_data     = pd;
        bus.mdu_valid     = mv;
        bus.mdu_rd        = mrd;
        bus.mdu_data      = md;
        bus.query_rs1     = q1;
        bus.query_rs2     = q2;
        #1;
        o_ready = bus.mdu_ready;
        o_stall = bus.pipe_stall;
        o_h1    = bus.hit_rs1;
        o_h2    = bus.hit_rs2;

        x_ready = !r && (m_q.size() < 2);
        x_stall = !r && model_stall();
        x_h1    = !r && (q1 != 0) && in_q(q1);
        x_h2    = !r && (q2 != 0) && in_q(q2);
        check("mdu_ready", o_ready, x_ready);
        check("pipe_stall", o_stall, x_stall);
        check("hit_rs1", o_h1, x_h1);
        check("hit_rs2", o_h2, x_h2);
        check("stall_back_to_back", prev_stall && o_stall, 1'b0);
        prev_stall = o_stall;

        if (r) begin
            m_q.delete();
            m_starve = 0;
            e_we = 1'b0; e_rd = '0; e_wdata = '0;
        end else begin
            popped    = 1'b0;
            was_empty = (m_q.size() == 0);
            live      = pv && pw && (prd != 0) && !x_stall;
            if (x_stall) begin
                e_we = 1'b1; e_rd = m_q[0].rd; e_wdata = m_q[0].data;
                void'(m_q.pop_front()); popped = 1'b1;
            end else if (live) begin
                e_we = 1'b1; e_rd = prd; e_wdata = pd;
            end else if (!was_empty) begin
                e_we = 1'b1; e_rd = m_q[0].rd; e_wdata = m_q[0].data;
                void'(m_q.pop_front()); popped = 1'b1;
            end else begin
                e_we = 1'b0;
            end
            m_starve = (popped || was_empty) ? 0 : m_starve + 1;
            if (mv && x_ready && (mrd != 0)) m_q.push_back('{rd: mrd, data: md});
        end

        @(posedge clk);
        #1;
        check("rf_we", bus.rf_we, e_we);
        check("rf_rd", bus.rf_rd, e_rd);
        check("rf_wdata", bus.rf_wdata, e_wdata);
        @(negedge clk);
    endtask

    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic rdy, stl, h1, h2;
        int   first_stall;
        int   p;
        logic [4:0]  hold_rd;
        logic [31:0] hold_data;
        logic        hold_pv, hold_pw, hold_live;

        clk = 1'b0;
        rst = 1'b1;
        bus.pipe_valid = 0; bus.pipe_regwrite = 0; bus.pipe_rd = '0; bus.pipe_data = '0;
        bus.mdu_valid = 0; bus.mdu_rd = '0; bus.mdu_data = '0;
        bus.query_rs1 = '0; bus.query_rs2 = '0;

        //            r     pv    pw    prd    pdata         mv    mrd    mdata          q1     q2     rdy   stl   h1    h2    we    rd     wdata
        tbl[0] = '{1'b0, 1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_1234};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'hDEAD_BEEF};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'hDEAD_BEEF};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'hDEAD_BEEF};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 5'd9, 32'h0000_0055, 1'b1, 5'd3, 32'h0000_0033, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'hDEAD_BEEF};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 5'd0, 32'h0000_0066, 1'b0, 5'd0, 32'h0,         5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0033};

        @(negedge clk);
        repeat (2) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, stl, h1, h2);
        check("reset_rf_we", bus.rf_we, 1'b0);
        check("reset_rf_rd", bus.rf_rd, 5'd0);
        check("reset_rf_wdata", bus.rf_wdata, 32'h0);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].r, tbl[i].pv, tbl[i].pw, tbl[i].prd, tbl[i].pdata,
                  tbl[i].mv, tbl[i].mrd, tbl[i].mdata, tbl[i].q1, tbl[i].q2,
                  rdy, stl, h1, h2);
            check($sformatf("vec%0d_ready", i), rdy, tbl[i].x_ready);
            check($sformatf("vec%0d_stall", i), stl, tbl[i].x_stall);
            check($sformatf("vec%0d_hit1", i), h1, tbl[i].x_h1);
            check($sformatf("vec%0d_hit2", i), h2, tbl[i].x_h2);
            check($sformatf("vec%0d_we", i), bus.rf_we, tbl[i].x_we);
            check($sformatf("vec%0d_rd", i), bus.rf_rd, tbl[i].x_rd);
            check($sformatf("vec%0d_wdata", i), bus.rf_wdata, tbl[i].x_wdata);
        end

        // Fill FIFO, then starve it with continuous pipeline writes
        apply(0, 1, 1, 5'd1, 32'h100, 1, 5'd10, 32'hA0, 0, 0, rdy, stl, h1, h2);
        apply(0, 1, 1, 5'd2, 32'h101, 1, 5'd11, 32'hB1, 0, 0, rdy, stl, h1, h2);
        first_stall = -1;
        p = 0;
        for (int k = 0; k < 6; k++) begin
            apply(0, 1, 1, 5'(3 + p), 32'h102 + 32'(p), (k <= 4), 5'd12, 32'hC2, 5'd10, 5'd11,
                  rdy, stl, h1, h2);
            if (stl && first_stall < 0) first_stall = k;
            if (k < 3) check("full_not_ready", rdy, 1'b0);
            if (k == 3) begin
                check("forced_drain_head_rd", bus.rf_rd, 5'd10);
                check("forced_drain_head_data", bus.rf_wdata, 32'hA0);
            end
            if (k == 4) begin
                check("ready_after_drain", rdy, 1'b1);
                check("held_pipe_rd", bus.rf_rd, 5'd6);
                check("held_pipe_data", bus.rf_wdata, 32'h105);
            end
            if (!stl) p++;
        end
        check("stall_in_5th_blocked_cycle", 32'(first_stall), 32'd3);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, stl, h1, h2);
        check("order_first_rd", bus.rf_rd, 5'd11);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, stl, h1, h2);
        check("order_second_rd", bus.rf_rd, 5'd12);
        check("order_second_data", bus.rf_wdata, 32'hC2);

        // Reset with two buffered entries and starve counter at 3
        apply(0, 1, 1, 5'd1, 32'h200, 1, 5'd20, 32'h20, 0, 0, rdy, stl, h1, h2);
        apply(0, 1, 1, 5'd2, 32'h201, 1, 5'd21, 32'h21, 0, 0, rdy, stl, h1, h2);
        apply(0, 1, 1, 5'd3, 32'h202, 0, 0, 0, 0, 0, rdy, stl, h1, h2);
        apply(0, 1, 1, 5'd4, 32'h203, 0, 0, 0, 0, 0, rdy, stl, h1, h2);
        apply(1, 1, 1, 5'd5, 32'h204, 1, 5'd22, 32'h22, 5'd20, 5'd21, rdy, stl, h1, h2);
        check("rst_ready", rdy, 1'b0);
        check("rst_hit1", h1, 1'b0);
        check("rst_hit2", h2, 1'b0);
        check("rst_rf_we", bus.rf_we, 1'b0);
        check("rst_rf_rd", bus.rf_rd, 5'd0);
        check("rst_rf_wdata", bus.rf_wdata, 32'h0);
        for (int k = 0; k < 4; k++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, 5'd20, 5'd21, rdy, stl, h1, h2);
            check("no_stale_write", bus.rf_we, 1'b0);
        end

        // Random traffic against the reference model
        hold_live = 1'b0;
        hold_pv = 0; hold_pw = 0; hold_rd = '0; hold_data = '0;
        for (int n = 0; n < 3000; n++) begin
            logic r;
            r = ($urandom_range(0, 99) == 0);
            if (!(model_stall() && hold_live)) begin
                hold_pv   = ($urandom_range(0, 9) < 6);
                hold_pw   = ($urandom_range(0, 9) < 8);
                hold_rd   = 5'($urandom_range(0, 7));
                hold_data = $urandom;
            end
            apply(r, hold_pv, hold_pw, hold_rd, hold_data,
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  rdy, stl, h1, h2);
            hold_live = hold_pv && hold_pw && (hold_rd != 0) && !r;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive blocked cycles before a forced MDU drain (legal range 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 pipe_valid  input  1  SHALL mark a valid pipeline writeback this cycle.
REQ-005 pipe_regwrite  input  1  SHALL be the pipeline write enable.
REQ-006 pipe_rd  input  5  SHALL be the pipeline destination register.
REQ-007 pipe_data  input  32  SHALL be the pipeline write data (already mem/ALU selected).
REQ-008 mdu_valid  input  1  SHALL mark a valid multi-cycle unit (MUL/DIV) result.
REQ-009 mdu_rd  input  5  SHALL be the MDU destination register.
REQ-010 mdu_data  input  32  SHALL be the MDU result.
REQ-011 mdu_ready  output  1  SHALL indicate the arbiter accepts an MDU result this cycle.
REQ-012 query_rs1, query_rs2  input  5 each  SHALL be decode-stage source registers for hazard lookup.
REQ-013 hit_rs1, hit_rs2  output  1 each  SHALL flag a pending buffered MDU write to the queried register.
REQ-014 pipe_stall  output  1  SHALL tell the pipeline its writeback is not taken this cycle and must be held.
REQ-015 rf_we, rf_rd (5), rf_wdata (32)  outputs  SHALL drive the single register-file write port, registered.

Function
REQ-016 A pipeline write is "live" when pipe_valid && pipe_regwrite && pipe_rd != 0 && !pipe_stall.
REQ-017 MDU results SHALL be held in a 2-entry FIFO, in order; mdu_ready = !rst && count < 2, combinational from state.
REQ-018 Push SHALL occur when mdu_valid && mdu_ready; a push with mdu_rd == 0 is accepted and discarded (no entry).
REQ-019 Port grant per cycle, strict order: (a) forced drain if pipe_stall; (b) live pipeline write; (c) FIFO head if count > 0; (d) idle.
REQ-020 The granted write SHALL appear on rf_we/rf_rd/rf_wdata one cycle later (registered); idle cycle drives rf_we = 0, rf_rd/rf_wdata hold previous values.
REQ-021 Pipeline latency SHALL be 1 cycle input-to-rf_we; an MDU entry pushed at edge N is eligible no earlier than cycle N+1 (no bypass), minimum latency 2.
REQ-022 A pop and a push in the same cycle SHALL both take effect; count unchanged, order preserved.
REQ-023 Starve counter (4 bits): increments each cycle count > 0 and no pop; clears on pop or when count == 0.
REQ-024 pipe_stall SHALL be 1 exactly when starve counter == STARVE_LIMIT and count > 0, combinational from state; that cycle the head pops and the counter clears.
REQ-025 pipe_stall SHALL never assert in two consecutive cycles.
REQ-026 hit_rsX SHALL be 1 when query_rsX != 0 and matches rd of any valid FIFO entry, combinational; entry being popped this cycle still hits.
REQ-027 Pipeline and FIFO writes to the same rd SHALL retire in grant order; no merging or suppression.
REQ-028 pipe_valid with pipe_regwrite = 0 or pipe_rd = 0 SHALL not consume the port; FIFO head may drain that cycle.

Reset
REQ-029 While rst = 1 at a clock edge: FIFO count = 0, starve counter = 0, rf_we = 0, rf_rd = 0, rf_wdata = 0.
REQ-030 During rst, mdu_ready = 0, pipe_stall = 0, hit_rs1 = hit_rs2 = 0; buffered entries are discarded, none written after reset.
REQ-031 First grant SHALL occur in the first cycle with rst = 0.

Verification
REQ-032 Pipe write rd=5, data=0x1234 with no MDU traffic -> next cycle rf_we=1, rf_rd=5, rf_wdata=0x00001234; pipe_stall stays 0.
REQ-033 MDU push rd=7, data=0xDEADBEEF, pipeline idle -> hit_rs1=1 for query_rs1=7 next cycle; rf_we=1, rf_rd=7 two cycles after push; hit clears.
REQ-034 Two MDU pushes then continuous live pipeline writes, STARVE_LIMIT=4 -> mdu_ready=0 while full; pipe_stall=1 in the 5th blocked cycle; head written next; pipeline write held and written after the stall.
REQ-035 FIFO full, same cycle pop and mdu_valid -> no push (ready=0); next cycle count=1, ready=1, push then accepted with order preserved.
REQ-036 MDU push with mdu_rd=0, data=0xFFFFFFFF -> accepted, count stays 0, rf_we never asserts for it.
REQ-037 rst asserted with 2 entries buffered and starve counter at 3 -> next cycle rf_we=0, outputs zeroed, count=0; after release no stale write appears.
